// File: rtl/ascon_block_packer_if.sv
// Bus bundle between the byte source / ASCON core and the block packer.
// The packer uses the slave modport; the driving side (source + core) uses master.
interface ascon_block_packer_if #(
    parameter int RATE = 64
);
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic            core_start;
    logic [RATE-1:0] core_data;
    logic            core_last;
    logic [3:0]      core_nbytes;
    logic            core_done;
    logic            busy;

    modport master (
        output in_data, in_valid, in_last, core_done,
        input  in_ready, core_start, core_data, core_last, core_nbytes, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, core_done,
        output in_ready, core_start, core_data, core_last, core_nbytes, busy
    );
endinterface

// File: rtl/ascon_block_packer.sv
// Packs a byte stream MSB-first into RATE-bit blocks with ASCON-128 0x80 padding
// and hands each block to the core with a one-cycle start pulse.
module ascon_block_packer #(
    parameter int RATE = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ascon_block_packer_if.slave  bus
);
    localparam int RATE_BYTES = RATE / 8;
    localparam int CNT_W      = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_BYTES - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_PAD
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [RATE-1:0]  r_buf;
    logic [3:0]       r_nbytes;
    logic             r_last;
    logic             r_pad_pending;

    logic             w_accept;
    logic             w_block_end;
    logic             w_short_last;
    logic [RATE-1:0]  w_fill_buf;

    // Unfilled bytes are already zero, so only the data byte and the pad byte are written.
    always_comb begin
        w_accept     = (r_state == S_FILL) && bus.in_valid;
        w_block_end  = w_accept && (bus.in_last || (r_count == LAST_IDX));
        w_short_last = bus.in_last && (r_count != LAST_IDX);
        w_fill_buf   = r_buf;
        for (int b = 0; b < RATE_BYTES; b++) begin
            if (b == int'(r_count)) begin
                w_fill_buf[RATE-1-8*b -: 8] = bus.in_data;
            end else if (bus.in_last && (b == int'(r_count) + 1)) begin
                w_fill_buf[RATE-1-8*b -: 8] = 8'h80;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:  w_next_state = S_FILL;
            S_FILL:  if (w_block_end) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (bus.core_done) begin
                    w_next_state = r_pad_pending ? S_PAD : S_FILL;
                end
            end
            S_PAD:   w_next_state = S_ISSUE;
            default: w_next_state = S_INIT;
        endcase
    end

    // A full block ending the message defers its padding to a separate block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_buf         <= '0;
            r_nbytes      <= '0;
            r_last        <= 1'b0;
            r_pad_pending <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_buf <= w_fill_buf;
                        if (w_block_end) begin
                            r_count       <= '0;
                            r_nbytes      <= 4'(int'(r_count) + 1);
                            r_last        <= w_short_last;
                            r_pad_pending <= bus.in_last && !w_short_last;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.core_done && !r_pad_pending) begin
                        r_buf <= '0;
                    end
                end
                S_PAD: begin
                    r_buf         <= {8'h80, {(RATE-8){1'b0}}};
                    r_nbytes      <= 4'd0;
                    r_last        <= 1'b1;
                    r_pad_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_FILL);
    assign bus.core_start  = (r_state == S_ISSUE);
    assign bus.busy        = (r_state != S_FILL);
    assign bus.core_data   = r_buf;
    assign bus.core_last   = r_last;
    assign bus.core_nbytes = r_nbytes;
endmodule

// File: tb/tb_ascon_block_packer.sv
// Directed bench for ascon_block_packer: padding cases, backpressure, spurious
// done pulses and reset while a pad block is pending.
module tb_ascon_block_packer;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    ascon_block_packer_if #(.RATE(64)) dut_if ();

    ascon_block_packer #(.RATE(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        while (dut_if.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut_if.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL send_ready: in_ready=%b required 1", dut_if.in_ready);
        end
        dut_if.in_data  = d;
        dut_if.in_valid = 1'b1;
        dut_if.in_last  = last;
        @(negedge clk);
        dut_if.in_valid = 1'b0;
        dut_if.in_last  = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (dut_if.core_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut_if.core_start !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s_start: core_start=%b required 1 within 50 cycles", name, dut_if.core_start);
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        checks++;
        if (dut_if.core_start !== 1'b0) begin
            fails++;
            $display("[TB] FAIL start_one_cycle: core_start=%b required 0", dut_if.core_start);
        end
        dut_if.core_done = 1'b1;
        @(negedge clk);
        dut_if.core_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (dut_if.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_in_ready: got %b required 0", dut_if.in_ready); end
        if (dut_if.core_start !== 1'b0) begin fails++; $display("[TB] FAIL rst_core_start: got %b required 0", dut_if.core_start); end
        if (dut_if.core_data !== 64'h0) begin fails++; $display("[TB] FAIL rst_core_data: got %h required 0", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd0) begin fails++; $display("[TB] FAIL rst_core_nbytes: got %0d required 0", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b0) begin fails++; $display("[TB] FAIL rst_core_last: got %b required 0", dut_if.core_last); end
        if (dut_if.busy !== 1'b1) begin fails++; $display("[TB] FAIL rst_busy: got %b required 1", dut_if.busy); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (dut_if.busy !== 1'b1) begin fails++; $display("[TB] FAIL init_busy: got %b required 1", dut_if.busy); end
        @(negedge clk);
        checks += 2;
        if (dut_if.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL fill_in_ready: got %b required 1", dut_if.in_ready); end
        if (dut_if.busy !== 1'b0) begin fails++; $display("[TB] FAIL fill_busy: got %b required 0", dut_if.busy); end
    endtask

    task automatic test_short_message();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        wait_start("short");
        checks += 3;
        if (dut_if.core_data !== 64'hAABBCC8000000000) begin fails++; $display("[TB] FAIL short_data: got %h required aabbcc8000000000", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd3) begin fails++; $display("[TB] FAIL short_nbytes: got %0d required 3", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b1) begin fails++; $display("[TB] FAIL short_last: got %b required 1", dut_if.core_last); end
        pulse_done();
        checks++;
        if (dut_if.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL short_ready_after: got %b required 1", dut_if.in_ready); end
    endtask

    task automatic test_full_with_pad();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_start("full");
        checks += 3;
        if (dut_if.core_data !== 64'h0102030405060708) begin fails++; $display("[TB] FAIL full_data: got %h required 0102030405060708", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd8) begin fails++; $display("[TB] FAIL full_nbytes: got %0d required 8", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b0) begin fails++; $display("[TB] FAIL full_last: got %b required 0", dut_if.core_last); end
        pulse_done();
        wait_start("pad");
        checks += 3;
        if (dut_if.core_data !== 64'h8000000000000000) begin fails++; $display("[TB] FAIL pad_data: got %h required 8000000000000000", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd0) begin fails++; $display("[TB] FAIL pad_nbytes: got %0d required 0", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b1) begin fails++; $display("[TB] FAIL pad_last: got %b required 1", dut_if.core_last); end
        pulse_done();
        checks++;
        if (dut_if.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL pad_ready_after: got %b required 1", dut_if.in_ready); end
    endtask

    task automatic test_ten_bytes();
        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0);
        wait_start("ten_a");
        checks += 3;
        if (dut_if.core_data !== 64'h1011121314151617) begin fails++; $display("[TB] FAIL ten_a_data: got %h required 1011121314151617", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd8) begin fails++; $display("[TB] FAIL ten_a_nbytes: got %0d required 8", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b0) begin fails++; $display("[TB] FAIL ten_a_last: got %b required 0", dut_if.core_last); end
        pulse_done();
        send_byte(8'h18, 1'b0);
        send_byte(8'h19, 1'b1);
        wait_start("ten_b");
        checks += 3;
        if (dut_if.core_data !== 64'h1819800000000000) begin fails++; $display("[TB] FAIL ten_b_data: got %h required 1819800000000000", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd2) begin fails++; $display("[TB] FAIL ten_b_nbytes: got %0d required 2", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b1) begin fails++; $display("[TB] FAIL ten_b_last: got %b required 1", dut_if.core_last); end
        pulse_done();
    endtask

    task automatic test_backpressure();
        int seen_ready = 0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b0);
        wait_start("bp");
        dut_if.in_data  = 8'h55;
        dut_if.in_valid = 1'b1;
        dut_if.in_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut_if.in_ready !== 1'b0) seen_ready++;
        end
        checks += 2;
        if (seen_ready != 0) begin fails++; $display("[TB] FAIL bp_ready_low: in_ready high %0d cycles required 0", seen_ready); end
        if (dut_if.core_data !== 64'hA0A1A2A3A4A5A6A7) begin fails++; $display("[TB] FAIL bp_data_held: got %h required a0a1a2a3a4a5a6a7", dut_if.core_data); end
        dut_if.core_done = 1'b1;
        @(negedge clk);
        dut_if.core_done = 1'b0;
        checks++;
        if (dut_if.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_ready_after: got %b required 1", dut_if.in_ready); end
        @(negedge clk);
        dut_if.in_valid = 1'b0;
        dut_if.in_last  = 1'b0;
        checks += 4;
        if (dut_if.core_start !== 1'b1) begin fails++; $display("[TB] FAIL bp_next_start: got %b required 1", dut_if.core_start); end
        if (dut_if.core_data !== 64'h5580000000000000) begin fails++; $display("[TB] FAIL bp_next_data: got %h required 5580000000000000", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd1) begin fails++; $display("[TB] FAIL bp_next_nbytes: got %0d required 1", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b1) begin fails++; $display("[TB] FAIL bp_next_last: got %b required 1", dut_if.core_last); end
        pulse_done();
    endtask

    task automatic test_spurious_done();
        dut_if.core_done = 1'b1;
        @(negedge clk);
        dut_if.core_done = 1'b0;
        checks += 2;
        if (dut_if.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL spur_fill_ready: got %b required 1", dut_if.in_ready); end
        if (dut_if.core_start !== 1'b0) begin fails++; $display("[TB] FAIL spur_fill_start: got %b required 0", dut_if.core_start); end
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b1);
        wait_start("spur");
        dut_if.core_done = 1'b1;
        @(negedge clk);
        dut_if.core_done = 1'b0;
        checks += 2;
        if (dut_if.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL spur_issue_ready: got %b required 0", dut_if.in_ready); end
        if (dut_if.busy !== 1'b1) begin fails++; $display("[TB] FAIL spur_issue_busy: got %b required 1", dut_if.busy); end
        repeat (3) @(negedge clk);
        checks += 3;
        if (dut_if.core_data !== 64'h3132800000000000) begin fails++; $display("[TB] FAIL spur_data_held: got %h required 3132800000000000", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd2) begin fails++; $display("[TB] FAIL spur_nbytes: got %0d required 2", dut_if.core_nbytes); end
        if (dut_if.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL spur_wait_ready: got %b required 0", dut_if.in_ready); end
        pulse_done();
        checks++;
        if (dut_if.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL spur_ready_after: got %b required 1", dut_if.in_ready); end
    endtask

    task automatic test_reset_in_wait();
        int starts = 0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), i == 7);
        wait_start("rw");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (dut_if.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL rw_in_ready: got %b required 0", dut_if.in_ready); end
        if (dut_if.core_start !== 1'b0) begin fails++; $display("[TB] FAIL rw_core_start: got %b required 0", dut_if.core_start); end
        if (dut_if.core_data !== 64'h0) begin fails++; $display("[TB] FAIL rw_core_data: got %h required 0", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd0) begin fails++; $display("[TB] FAIL rw_core_nbytes: got %0d required 0", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b0) begin fails++; $display("[TB] FAIL rw_core_last: got %b required 0", dut_if.core_last); end
        if (dut_if.busy !== 1'b1) begin fails++; $display("[TB] FAIL rw_busy: got %b required 1", dut_if.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dut_if.core_start === 1'b1) starts++;
        end
        checks += 2;
        if (starts != 0) begin fails++; $display("[TB] FAIL rw_no_pad: core_start seen %0d times required 0", starts); end
        if (dut_if.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rw_ready: got %b required 1", dut_if.in_ready); end
        send_byte(8'h42, 1'b1);
        wait_start("rw_fresh");
        checks += 3;
        if (dut_if.core_data !== 64'h4280000000000000) begin fails++; $display("[TB] FAIL rw_fresh_data: got %h required 4280000000000000", dut_if.core_data); end
        if (dut_if.core_nbytes !== 4'd1) begin fails++; $display("[TB] FAIL rw_fresh_nbytes: got %0d required 1", dut_if.core_nbytes); end
        if (dut_if.core_last !== 1'b1) begin fails++; $display("[TB] FAIL rw_fresh_last: got %b required 1", dut_if.core_last); end
        pulse_done();
    endtask

    initial begin
        clk              = 1'b0;
        rst_n            = 1'b0;
        checks           = 0;
        fails            = 0;
        dut_if.in_data   = 8'h00;
        dut_if.in_valid  = 1'b0;
        dut_if.in_last   = 1'b0;
        dut_if.core_done = 1'b0;
        test_reset();
        test_short_message();
        test_full_with_pad();
        test_ten_bytes();
        test_backpressure();
        test_spurious_done();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ascon_block_packer.md
Name: ascon_block_packer

Overview:
- Upstream feeder for the ASCON core: accepts a byte stream and assembles it into RATE-bit blocks, MSB-first.
- Applies ASCON-128 padding: a single 0x80 byte follows the last message byte, then zero fill.
- Issues one block at a time to the core with a one-cycle start pulse, then holds the block until the core reports done.
- Throttles the byte stream with a valid/ready handshake.

Parameters:
RATE, 64, block width in bits; must be a multiple of 8.
RATE_BYTES, RATE/8, bytes per block (derived; not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
in_data  in  8  message byte.
in_valid  in  1  in_data valid.
in_last  in  1  qualifies in_data as final message byte.
in_ready  out  1  packer can accept a byte this cycle.
core_start  out  1  one-cycle pulse: core_data/core_last/core_nbytes valid, core begins processing.
core_data  out  RATE  padded block; first message byte in [RATE-1:RATE-8].
core_last  out  1  block is final block of message.
core_nbytes  out  4  message bytes in block (0..RATE_BYTES), padding excluded.
core_done  in  1  core finished current block.
busy  out  1  high whenever state is not FILL.

Behaviour:
- Reset: rst low asynchronously forces state INIT, byte counter 0, buffer 0, pad_pending 0. Outputs during reset: in_ready 0, core_start 0, core_data 0, core_last 0, core_nbytes 0, busy 1.
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.
- States: INIT, FILL, ISSUE, WAIT, PAD.
- INIT -> FILL on the first clk edge after rst deasserts.
- FILL:
  - in_ready=1, busy=0.
  - Handshake: a byte is accepted on an edge with in_valid&in_ready.
  - Byte k (k = counter, 0-based) is written to buffer bits [RATE-1-8k -: 8]; counter increments.
  - in_valid is ignored while in_ready=0; the source holds data stable.
  - Exit on acceptance of byte RATE_BYTES-1, or of any byte with in_last=1 -> ISSUE. Block content is then latched:
    - Fewer than RATE_BYTES bytes and in_last: byte at position n = 0x80, remaining bytes 0; core_nbytes=n; core_last=1.
    - Full block and in_last: core_nbytes=RATE_BYTES, core_last=0, pad_pending=1.
    - Full block, no in_last: core_nbytes=RATE_BYTES, core_last=0.
  - Counter clears to 0 on exit (wrap-around).
- ISSUE:
  - core_start=1 for exactly one cycle, in_ready=0.
  - Next state WAIT unconditionally.
  - core_done sampled during ISSUE is ignored.
- WAIT:
  - core_data/core_last/core_nbytes held stable, in_ready=0.
  - On core_done=1: if pad_pending, go to PAD; else clear buffer and go to FILL.
  - Latency: first byte accepted in FILL no earlier than the cycle after core_done.
- PAD:
  - Load core_data = 0x80 followed by zeros, core_nbytes=0, core_last=1; clear pad_pending.
  - Next state ISSUE (the pad block takes one cycle in PAD, then the normal ISSUE/WAIT path).
- core_done in FILL, INIT or PAD is ignored.
- Zero-length messages are out of scope: every message carries at least one byte.
- Latency from accepting the block-completing byte to core_start: 1 cycle.
- Reset mid-operation (any state): immediate return to reset values; partially filled blocks and pending pad are discarded; no core_start is generated.

Test Plan:
- Three bytes 0xAA, 0xBB, 0xCC (last on 0xCC) -> one core_start; core_data=0xAABBCC8000000000, core_nbytes=3, core_last=1; after core_done, in_ready=1.
- Eight bytes 0x01..0x08, last on 0x08 -> block 0x0102030405060708, nbytes 8, last 0. After core_done: second pulse with 0x8000000000000000, nbytes 0, last 1.
- Ten bytes 0x10..0x19, last on 0x19 -> block 0x1011121314151617 (last 0). After done: 0x1819800000000000, nbytes 2, last 1.
- Backpressure: hold in_valid=1 with 0x55 throughout WAIT while core_done is delayed 20 cycles -> in_ready=0, byte not consumed. After done, 0x55 lands in [63:56] of the next block.
- Spurious core_done in FILL and during ISSUE -> no state change; core_data held until a core_done arrives in WAIT.
- rst low for 1 cycle during WAIT with pad_pending=1 -> all outputs reset values; after release no pad block is issued; a fresh 1-byte message 0x42 gives 0x4280000000000000, nbytes 1, last 1.
